// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared loader state encodings and instruction-memory address width
package imem_loader_pkg;

    localparam int IMEM_ADDR_W = 12;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DAT_LO = 3'd3,
        DAT_HI = 3'd4,
        CHK    = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write port of the loader
interface imem_loader_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed byte frame into instruction memory, holds CPU in reset until done
// Optional feature macro: LOADER_CHECKSUM_EN (trailing 8-bit sum byte checked before DONE).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam logic [16:0] MAX_WORDS = 17'((1 << ADDR_W) - BASE_ADDR);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_DATA = CHK;
`else
    localparam loader_state_t AFTER_DATA = DONE;
`endif

    loader_state_t state, nxt;
    logic [15:0]   count;
    logic [15:0]   len;
    logic [7:0]    lo;
    logic          ready;
    logic          acc;
    logic [15:0]   len_n;
    logic [15:0]   count_inc;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum;
`endif

    assign acc          = bus.in_valid && ready;
    assign len_n        = {bus.in_data, len[7:0]};
    assign count_inc    = count + 16'd1;
    assign bus.in_ready = ready;

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) nxt = LEN_LO;
            LEN_LO:          if (acc) nxt = LEN_HI;
            LEN_HI: begin
                if (acc) begin
                    if (len_n == 16'd0)
                        nxt = AFTER_DATA;
                    else if ({1'b0, len_n} > MAX_WORDS)
                        nxt = ERR;
                    else
                        nxt = DAT_LO;
                end
            end
            DAT_LO:          if (acc) nxt = DAT_HI;
            DAT_HI:          if (acc) nxt = (count_inc < len) ? DAT_LO : AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
            CHK:             if (acc) nxt = (bus.in_data == sum) ? DONE : ERR;
`endif
            default:         nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            count          <= '0;
            len            <= '0;
            lo             <= '0;
            ready          <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= ADDR_W'(BASE_ADDR);
            bus.imem_wdata <= '0;
            cpu_rst        <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum            <= '0;
`endif
        end else begin
            state       <= nxt;
            bus.imem_we <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            if (acc) sum <= sum + bus.in_data;
`endif
            case (state)
                LEN_LO: if (acc) len[7:0]  <= bus.in_data;
                LEN_HI: if (acc) len[15:8] <= bus.in_data;
                DAT_LO: if (acc) lo        <= bus.in_data;
                DAT_HI: begin
                    // Address and data are registered together so the strobe sees a stable pair.
                    if (acc) begin
                        bus.imem_wdata <= {bus.in_data, lo};
                        bus.imem_addr  <= ADDR_W'(BASE_ADDR) + count[ADDR_W-1:0];
                        bus.imem_we    <= 1'b1;
                        count          <= count_inc;
                    end
                end
                default: ;
            endcase

            if (nxt != state) begin
                case (nxt)
                    LEN_LO: begin
                        ready   <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        error   <= 1'b0;
                        cpu_rst <= 1'b1;
                        count   <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum     <= '0;
`endif
                    end
                    DONE: begin
                        ready   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end
                    ERR: begin
                        ready   <= 1'b0;
                        busy    <= 1'b0;
                        error   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
